fifo1c_rd_stream: RTL and testbench

Read-side drain engine for the single-clock fifo1c FIFO family in the link engine. It issues `fifo_rdreq` against the FIFO status and absorbs the FIFO's fixed read latency in a small registered holding buffer. It presents the words downstream as a valid/ready stream with full throughput and no bubbles. It also provides flush, idle status and a word counter for the stats path.

---
 rtl/fifo1c_rd_stream.sv | 129 ++++++++++++
 tb/tb_fifo1c_rd_stream.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo1c_rd_stream.sv
// rtl/fifo1c_rd_stream.sv - fifo1c read-side drain engine with latency-absorbing holding buffer
module fifo1c_rd_stream #(
    parameter int DATA_WIDTH = 108,
    parameter int RD_LATENCY = 1,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_q,
    output logic                  fifo_rdreq,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    input  logic                  flush,
    input  logic                  cnt_clr,
    output logic                  idle,
    output logic [31:0]           cnt_out
);

    // Pointer width stays at least one bit so a single-entry buffer still elaborates.
    localparam int PTR_W  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int OCC_W  = $clog2(BUF_DEPTH + 1);
    localparam int INFL_W = $clog2(RD_LATENCY + 2);
    localparam int SUM_W  = OCC_W + 2;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [OCC_W-1:0]      occ;
    logic [INFL_W-1:0]     infl;
    logic                  ret_valid;
    logic                  pop;
    logic [SUM_W-1:0]      credit_used;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // A pop in the flush cycle is void: it neither moves the buffer nor counts.
    assign pop = out_valid & out_ready & ~flush;

    // Credit: entries held plus reads still returning, minus the slot freed this cycle.
    always_comb begin
        credit_used = SUM_W'(occ) + SUM_W'(infl) - SUM_W'(pop);
    end

    assign fifo_rdreq = ~fifo_empty & ~flush & ~rst & (credit_used < SUM_W'(BUF_DEPTH));

    assign out_valid = (occ != '0);
    assign out_data  = mem[rd_ptr];
    assign idle      = (occ == '0) & (infl == '0);

    generate
        if (RD_LATENCY == 0) begin : g_show_ahead
            // Show-ahead FIFO: the word is on fifo_q in the request cycle itself.
            assign ret_valid = fifo_rdreq;
            assign infl      = '0;
        end else begin : g_pipe
            logic [RD_LATENCY-1:0] sr_vld;
            logic [RD_LATENCY-1:0] sr_dsc;

            // Track each outstanding read; a flush tags everything in flight for discard.
            always_ff @(posedge clk) begin
                if (rst) begin
                    sr_vld <= '0;
                    sr_dsc <= '0;
                end else begin
                    sr_vld[0] <= fifo_rdreq;
                    sr_dsc[0] <= 1'b0;
                    for (int i = 1; i < RD_LATENCY; i++) begin
                        sr_vld[i] <= sr_vld[i-1];
                        sr_dsc[i] <= sr_vld[i-1] & (sr_dsc[i-1] | flush);
                    end
                end
            end

            assign ret_valid = sr_vld[RD_LATENCY-1] & ~sr_dsc[RD_LATENCY-1];

            // Discarded reads still count as in flight until they retire.
            always_comb begin
                infl = '0;
                for (int i = 0; i < RD_LATENCY; i++) begin
                    infl = infl + INFL_W'(sr_vld[i]);
                end
            end
        end
    endgenerate

    // Holding buffer: capture returning words, retire accepted ones, empty on flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            occ    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (ret_valid) begin
                mem[wr_ptr] <= fifo_q;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (ret_valid & ~pop) begin
                occ <= occ + 1'b1;
            end else if (~ret_valid & pop) begin
                occ <= occ - 1'b1;
            end
        end
    end

    // Accepted-word counter for the stats path; clear wins over a same-cycle pop.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cnt_out <= '0;
        end else if (pop) begin
            cnt_out <= cnt_out + 32'd1;
        end
    end

endmodule

// File: tb/tb_fifo1c_rd_stream.sv
// tb/tb_fifo1c_rd_stream.sv - randomized and directed bench for fifo1c_rd_stream
module tb_fifo1c_rd_stream;

    localparam int DW = 108;
    localparam int NI = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          out_ready;
    logic          flush;
    logic          cnt_clr;
    int            push_n;
    logic [DW-1:0] push_base;

    wire [NI-1:0] rdreq_w;
    wire [NI-1:0] valid_w;
    wire [NI-1:0] idle_w;
    wire [DW-1:0] data_w [NI];
    wire [31:0]   cnt_w  [NI];

    int n_checks = 0;
    int n_errors = 0;
    int nreq;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] junk();
        logic [127:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_quiet();
        int quiet = 0;
        for (int k = 0; k < 400 && quiet < 4; k++) begin
            @(negedge clk);
            if (&idle_w) quiet++;
            else quiet = 0;
            tick();
        end
        check("drain_timeout", DW'(quiet >= 4), DW'(1));
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int L = (g == 0) ? 1 : ((g == 1) ? 2 : 0);
        localparam int D = (g == 1) ? 4 : 2;

        typedef struct packed {
            logic [DW-1:0] data;
            logic [7:0]    rem;
            logic          dsc;
        } rec_t;

        logic          fifo_empty = 1'b1;
        logic [DW-1:0] fifo_q = '0;
        logic [DW-1:0] fq [$];
        logic [DW-1:0] pipe [$];
        logic [DW-1:0] bq [$];
        rec_t          infl_q [$];
        logic [31:0]   cnt_m = '0;
        bit            armed = 1'b0;
        logic          s_rdreq = 1'b0;
        logic          s_exp = 1'b0;
        logic          s_pop = 1'b0;

        fifo1c_rd_stream #(
            .DATA_WIDTH(DW),
            .RD_LATENCY(L),
            .BUF_DEPTH (D)
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .fifo_empty(fifo_empty),
            .fifo_q    (fifo_q),
            .fifo_rdreq(rdreq_w[g]),
            .out_valid (valid_w[g]),
            .out_data  (data_w[g]),
            .out_ready (out_ready),
            .flush     (flush),
            .cnt_clr   (cnt_clr),
            .idle      (idle_w[g]),
            .cnt_out   (cnt_w[g])
        );

        always @(negedge clk) begin : chk
            logic pop_m;
            logic exp_rdreq;
            int   used;
            pop_m     = (bq.size() != 0) && out_ready && !flush;
            used      = bq.size() + infl_q.size() - (pop_m ? 1 : 0);
            exp_rdreq = (fq.size() != 0) && !flush && !rst && (used < D);
            if (armed) begin
                check($sformatf("i%0d.rdreq", g), DW'(rdreq_w[g]), DW'(exp_rdreq));
                check($sformatf("i%0d.valid", g), DW'(valid_w[g]), DW'(bq.size() != 0));
                check($sformatf("i%0d.idle", g), DW'(idle_w[g]),
                      DW'((bq.size() == 0) && (infl_q.size() == 0)));
                check($sformatf("i%0d.cnt", g), DW'(cnt_w[g]), DW'(cnt_m));
                if (bq.size() != 0) check($sformatf("i%0d.data", g), data_w[g], bq[0]);
            end
            s_rdreq = rdreq_w[g];
            s_exp   = exp_rdreq;
            s_pop   = pop_m;
        end

        always begin : upd
            logic [DW-1:0] w;
            rec_t          r;
            @(posedge clk);
            #1;
            armed = 1'b1;
            if (rst) begin
                bq.delete();
                infl_q.delete();
                fq.delete();
                cnt_m = '0;
            end else begin
                if (cnt_clr) cnt_m = '0;
                else if (s_pop) cnt_m = cnt_m + 32'd1;
                if (flush) bq.delete();
                else if (s_pop) void'(bq.pop_front());
                while (infl_q.size() != 0 && infl_q[0].rem == 8'd0) begin
                    r = infl_q.pop_front();
                    if (!r.dsc && !flush) bq.push_back(r.data);
                end
                for (int i = 0; i < infl_q.size(); i++) begin
                    r     = infl_q[i];
                    r.rem = r.rem - 8'd1;
                    r.dsc = r.dsc | flush;
                    infl_q[i] = r;
                end
                if (s_exp && fq.size() != 0) begin
                    if (L == 0) begin
                        bq.push_back(fq[0]);
                    end else begin
                        r.data = fq[0];
                        r.rem  = 8'(L - 1);
                        r.dsc  = 1'b0;
                        infl_q.push_back(r);
                    end
                end
            end
            w = junk();
            if (!rst && s_rdreq && fq.size() != 0) w = fq.pop_front();
            if (L > 0) begin
                pipe.push_front(w);
                while (pipe.size() > L) void'(pipe.pop_back());
                if (pipe.size() == L) fifo_q = pipe[pipe.size() - 1];
                else fifo_q = junk();
            end
            #2;
            for (int i = 0; i < push_n; i++) fq.push_back(push_base + DW'(i));
            fifo_empty = (fq.size() == 0);
            if (L == 0) fifo_q = (fq.size() != 0) ? fq[0] : junk();
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        out_ready = 1'b0;
        flush     = 1'b0;
        cnt_clr   = 1'b0;
        push_n    = 0;
        push_base = '0;
        repeat (3) tick();
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            check("reset_rdreq", DW'(rdreq_w[g]), DW'(0));
            check("reset_valid", DW'(valid_w[g]), DW'(0));
            check("reset_data", data_w[g], DW'(0));
            check("reset_idle", DW'(idle_w[g]), DW'(1));
            check("reset_cnt", DW'(cnt_w[g]), DW'(0));
        end
        tick();
        rst = 1'b0;

        // streaming 0x1..0x20 with out_ready held high
        out_ready = 1'b1;
        push_base = DW'(1);
        push_n    = 32;
        tick();
        push_n = 0;
        repeat (40) tick();
        @(negedge clk);
        for (int g = 0; g < NI; g++) check("stream_cnt", DW'(cnt_w[g]), DW'(32));
        wait_quiet();

        // backpressure: 10 words, ready low
        out_ready = 1'b0;
        cnt_clr   = 1'b1;
        tick();
        cnt_clr   = 1'b0;
        push_base = DW'(100);
        push_n    = 10;
        nreq      = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            nreq = nreq + int'(rdreq_w[0]);
            tick();
            push_n = 0;
        end
        check("bp_rdreq_pulses", DW'(nreq), DW'(2));
        @(negedge clk);
        check("bp_valid", DW'(valid_w[0]), DW'(1));
        check("bp_cnt", DW'(cnt_w[0]), DW'(0));
        tick();
        for (int k = 0; k < 80; k++) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        out_ready = 1'b1;
        wait_quiet();
        @(negedge clk);
        check("bp_total", DW'(cnt_w[0]), DW'(10));
        tick();

        // flush with a read in flight (latency-2 instance)
        push_base = DW'(200);
        push_n    = 1;
        @(negedge clk);
        check("flush_rdreq", DW'(rdreq_w[1]), DW'(1));
        tick();
        push_n = 0;
        flush  = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        @(negedge clk);
        check("flush_idle", DW'(idle_w[1]), DW'(1));
        check("flush_valid", DW'(valid_w[1]), DW'(0));
        tick();
        push_base = DW'(300);
        push_n    = 1;
        tick();
        push_n = 0;
        wait_quiet();
        @(negedge clk);
        for (int g = 0; g < NI; g++) check("flush_cnt", DW'(cnt_w[g]), DW'(11));
        tick();

        // show-ahead single word
        push_base = DW'(12'hABC);
        push_n    = 1;
        @(negedge clk);
        check("sa_rdreq", DW'(rdreq_w[2]), DW'(1));
        tick();
        push_n = 0;
        @(negedge clk);
        check("sa_valid", DW'(valid_w[2]), DW'(1));
        check("sa_data", data_w[2], DW'(12'hABC));
        tick();
        @(negedge clk);
        check("sa_idle", DW'(idle_w[2]), DW'(1));
        tick();
        wait_quiet();

        // cnt_clr coincident with a pop
        push_base = DW'(400);
        push_n    = 6;
        tick();
        push_n = 0;
        tick();
        tick();
        cnt_clr = 1'b1;
        @(negedge clk);
        check("clr_pop_valid", DW'(valid_w[0]), DW'(1));
        tick();
        cnt_clr = 1'b0;
        @(negedge clk);
        check("clr_pop_cnt", DW'(cnt_w[0]), DW'(0));
        tick();
        wait_quiet();

        // reset mid-stream
        push_base = DW'(500);
        push_n    = 20;
        tick();
        push_n = 0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            check("rst_mid_valid", DW'(valid_w[g]), DW'(0));
            check("rst_mid_cnt", DW'(cnt_w[g]), DW'(0));
            check("rst_mid_idle", DW'(idle_w[g]), DW'(1));
        end
        tick();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("rst_no_stale", DW'(valid_w), DW'(0));
            tick();
        end

        // randomized traffic against the reference model
        for (int k = 0; k < 2000; k++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            push_n    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            push_base = junk();
            flush     = ($urandom_range(0, 59) == 0);
            cnt_clr   = ($urandom_range(0, 49) == 0);
            rst       = ($urandom_range(0, 399) == 0);
            tick();
        end
        push_n    = 0;
        flush     = 1'b0;
        cnt_clr   = 1'b0;
        rst       = 1'b0;
        out_ready = 1'b1;
        wait_quiet();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
